// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle for the bit-serial subtractor (overflow present under SERIAL_SUB_OVF_EN)
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic overflow;
  modport master(output start, a, b, input busy, done, diff, borrow, overflow);
  modport slave(input start, a, b, output busy, done, diff, borrow, overflow);
`else
  modport master(output start, a, b, input busy, done, diff, borrow);
  modport slave(input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b with borrow out; signed overflow flag under SERIAL_SUB_OVF_EN
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] nres;
  logic [CW-1:0] cnt;
  logic br;
  logic d;
  logic brn;
  logic last;
  // one full-subtractor bit slice on the current operand LSBs
  always_comb begin
    d = sa[0] ^ sb[0] ^ br;
    brn = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    nres = {d, res};
    last = cnt == CW'(WIDTH - 1);
  end
  // FSM with registered busy/done and result capture on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      sa <= '0;
      sb <= '0;
      res <= '0;
      br <= 1'b0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      bus.overflow <= 1'b0;
`endif
    end else if (st != RUN) begin
      bus.done <= 1'b0;
      if (bus.start) begin
        st <= RUN;
        sa <= bus.a;
        sb <= bus.b;
        br <= 1'b0;
        cnt <= '0;
        bus.busy <= 1'b1;
      end else begin
        st <= IDLE;
        bus.busy <= 1'b0;
      end
    end else begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      res <= nres[WIDTH-1:1];
      br <= brn;
      cnt <= cnt + 1'b1;
      if (last) begin
        st <= DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.diff <= nres;
        bus.borrow <= brn;
`ifdef SERIAL_SUB_OVF_EN
        bus.overflow <= (sa[0] ^ sb[0]) & (d ^ sa[0]);
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven and sequence checks of serial_subtractor with a result scoreboard
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  int compared = 0;
  int mismatched = 0;
  typedef struct {
    logic [7:0] d;
    logic br;
    logic ov;
  } exp_t;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic br;
    logic ov;
  } vec_t;
  exp_t sbq[$];
  vec_t tbl[10];
  vec_t bb[3];
  serial_subtractor_if #(.WIDTH(8)) bus();
  serial_subtractor #(.WIDTH(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic push(input vec_t v);
    exp_t e;
    e.d = v.d;
    e.br = v.br;
    e.ov = v.ov;
    sbq.push_back(e);
  endtask
  task automatic wait_done();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.done && n < 20);
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask
  task automatic op(input vec_t v);
    @(negedge clk);
    bus.a = v.a;
    bus.b = v.b;
    bus.start = 1'b1;
    @(posedge clk);
    push(v);
    #1 bus.start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("diff_hold", bus.diff, v.d);
  endtask
  always @(negedge clk) begin
    if (bus.busy && bus.done) chk("busy_and_done", 1, 0);
    if (!rst && bus.done) begin
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("diff", bus.diff, e.d);
        chk("borrow", bus.borrow, e.br);
`ifdef SERIAL_SUB_OVF_EN
        chk("overflow", bus.overflow, e.ov);
`endif
      end
    end
  end
  initial begin
    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[6] = '{8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0};
    tbl[7] = '{8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0};
    tbl[8] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    tbl[9] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    bb[0] = '{8'h20, 8'h10, 8'h10, 1'b0, 1'b0};
    bb[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    bb[2] = '{8'h81, 8'h02, 8'h7F, 1'b0, 1'b1};
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 8'h05;
    bus.b = 8'h03;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_borrow", bus.borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_overflow", bus.overflow, 0);
`endif
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    push(tbl[0]);
    #1;
    chk("first_accept_busy", bus.busy, 1);
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("latency_early", bus.done, 0);
    @(posedge clk);
    #1;
    chk("latency_done", bus.done, 1);
    chk("done_not_busy", bus.busy, 0);
    @(posedge clk);
    #1 chk("done_one_cycle", bus.done, 0);
    for (int i = 0; i < 10; i++) op(tbl[i]);
    @(negedge clk);
    bus.a = 8'h10;
    bus.b = 8'h01;
    bus.start = 1'b1;
    @(posedge clk);
    push('{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0});
    #1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    wait_done();
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("start_ignored_idle", bus.busy, 0);
    chk("ignored_diff_hold", bus.diff, 8'h0F);
    @(negedge clk);
    bus.a = 8'h80;
    bus.b = 8'h01;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_diff", bus.diff, 0);
    chk("abort_borrow", bus.borrow, 0);
    @(negedge clk) rst = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("abort_no_done", bus.done, 0);
    op('{8'h09, 8'h04, 8'h05, 1'b0, 1'b0});
    @(negedge clk);
    bus.a = bb[0].a;
    bus.b = bb[0].b;
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      push(bb[k]);
      #1;
      if (k < 2) begin
        bus.a = bb[k+1].a;
        bus.b = bb[k+1].b;
      end
      chk("b2b_busy", bus.busy, 1);
      repeat (7) @(posedge clk);
      #1 chk("b2b_early", bus.done, 0);
      @(posedge clk);
      #1 chk("b2b_done", bus.done, 1);
      if (k == 2) bus.start = 1'b0;
    end
    repeat (12) @(posedge clk);
    #1 chk("b2b_idle", bus.busy, 0);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
